// File: rtl/returner_pkg.sv
// Shared types for the in-order completion returner: per-slot bookkeeping,
// completion channel kinds and tag-width derivation.
package returner_pkg;

  typedef struct packed {
    logic alloc;
    logic valid;
  } slot_t;

  typedef enum logic {
    CPL_RD = 1'b0,
    CPL_WR = 1'b1
  } cpl_kind_e;

  function automatic int tag_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cpl_reorder_ring.sv
// One tag-indexed reorder ring: in-order allocation, out-of-order completion,
// in-order retirement through a registered valid/ready output stage.
module cpl_reorder_ring
  import returner_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 64,
  parameter bit HAS_DATA = 1'b1,
  localparam int TAG_W = tag_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc,
  output logic                  alloc_ok,
  output logic [TAG_W-1:0]      alloc_tag,
  input  logic                  cpl_valid,
  input  logic [TAG_W-1:0]      cpl_tag,
  input  logic [DATA_WIDTH-1:0] cpl_data,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data,
  input  logic                  ready,
  output logic                  err
);

  // Handshake: done/data form a valid/ready pair. A return is consumed on a
  // cycle where done && ready; while done && !ready, done and data hold.

  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);
  localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W + 1)'(1);
  localparam logic [TAG_W:0]   FULL_CNT = (TAG_W + 1)'(DEPTH);

  slot_t                 slot_q [DEPTH];
  slot_t                 slot_d [DEPTH];
  logic [TAG_W-1:0]      head_q, head_d;
  logic [TAG_W-1:0]      tail_q, tail_d;
  logic [TAG_W:0]        count_q, count_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;

  logic                  alloc_acc;
  logic                  cpl_ok;
  logic                  retire;
  logic [DATA_WIDTH-1:0] head_data;

  assign alloc_ok  = (count_q != FULL_CNT);
  assign alloc_tag = tail_q;
  assign alloc_acc = alloc && alloc_ok;
  assign cpl_ok    = cpl_valid && slot_q[cpl_tag].alloc && !slot_q[cpl_tag].valid;
  assign retire    = slot_q[head_q].valid && (!done_q || ready);

  // The payload store only exists for the read ring.
  if (HAS_DATA) begin : g_data
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
      if (cpl_ok) begin
        mem_q[cpl_tag] <= cpl_data;
      end
    end

    assign head_data = mem_q[head_q];
  end else begin : g_no_data
    logic unused_cpl_data;

    assign unused_cpl_data = ^cpl_data;
    assign head_data       = '0;
  end

  always_comb begin
    slot_d  = slot_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    done_d  = done_q;
    data_d  = data_q;
    err_d   = err_q;

    if (alloc_acc) begin
      slot_d[tail_q].alloc = 1'b1;
      tail_d               = tail_q + TAG_ONE;
    end

    // A completion landing on the slot being retired sees valid already set
    // and is therefore flagged rather than applied.
    if (cpl_valid) begin
      if (cpl_ok) begin
        slot_d[cpl_tag].valid = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    if (retire) begin
      slot_d[head_q] = '0;
      head_d         = head_q + TAG_ONE;
      done_d         = 1'b1;
      data_d         = head_data;
    end else if (ready) begin
      done_d = 1'b0;
      data_d = '0;
    end

    case ({alloc_acc, retire})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q  <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      done_q  <= done_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign done = done_q;
  assign data = data_q;
  assign err  = err_q;

endmodule

// File: rtl/completion_returner.sv
// Returns read and write completions in issue order; two independent reorder
// rings, the read ring carrying payload and the write ring status only.
module completion_returner
  import returner_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 64,
  localparam int TAG_W = tag_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_alloc,
  output logic                  rd_alloc_ok,
  output logic [TAG_W-1:0]      rd_alloc_tag,
  input  logic                  wr_alloc,
  output logic                  wr_alloc_ok,
  output logic [TAG_W-1:0]      wr_alloc_tag,
  input  logic                  rd_cpl_valid,
  input  logic [TAG_W-1:0]      rd_cpl_tag,
  input  logic [DATA_WIDTH-1:0] rd_cpl_data,
  input  logic                  wr_cpl_valid,
  input  logic [TAG_W-1:0]      wr_cpl_tag,
  output logic                  read_done,
  output logic [DATA_WIDTH-1:0] data,
  input  logic                  rd_ready,
  output logic                  write_done,
  input  logic                  wr_ready,
  output logic [1:0]            cpl_err
);

  logic                  rd_err;
  logic                  wr_err;
  logic [DATA_WIDTH-1:0] wr_data_unused;

  cpl_reorder_ring #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .HAS_DATA   (1'b1)
  ) u_rd_ring (
    .clk       (clk),
    .rst       (rst),
    .alloc     (rd_alloc),
    .alloc_ok  (rd_alloc_ok),
    .alloc_tag (rd_alloc_tag),
    .cpl_valid (rd_cpl_valid),
    .cpl_tag   (rd_cpl_tag),
    .cpl_data  (rd_cpl_data),
    .done      (read_done),
    .data      (data),
    .ready     (rd_ready),
    .err       (rd_err)
  );

  cpl_reorder_ring #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .HAS_DATA   (1'b0)
  ) u_wr_ring (
    .clk       (clk),
    .rst       (rst),
    .alloc     (wr_alloc),
    .alloc_ok  (wr_alloc_ok),
    .alloc_tag (wr_alloc_tag),
    .cpl_valid (wr_cpl_valid),
    .cpl_tag   (wr_cpl_tag),
    .cpl_data  ('0),
    .done      (write_done),
    .data      (wr_data_unused),
    .ready     (wr_ready),
    .err       (wr_err)
  );

  assign cpl_err = {wr_err, rd_err};

endmodule

// File: tb/tb_completion_returner.sv
// Bench for completion_returner: directed scenarios plus random traffic, all
// checked cycle by cycle against an issue-order queue model.
module tb_completion_returner;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int TW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_alloc, wr_alloc;
  logic          rd_alloc_ok, wr_alloc_ok;
  logic [TW-1:0] rd_alloc_tag, wr_alloc_tag;
  logic          rd_cpl_valid, wr_cpl_valid;
  logic [TW-1:0] rd_cpl_tag, wr_cpl_tag;
  logic [DW-1:0] rd_cpl_data;
  logic          read_done, write_done;
  logic [DW-1:0] data;
  logic          rd_ready, wr_ready;
  logic [1:0]    cpl_err;

  completion_returner #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_alloc     (rd_alloc),
    .rd_alloc_ok  (rd_alloc_ok),
    .rd_alloc_tag (rd_alloc_tag),
    .wr_alloc     (wr_alloc),
    .wr_alloc_ok  (wr_alloc_ok),
    .wr_alloc_tag (wr_alloc_tag),
    .rd_cpl_valid (rd_cpl_valid),
    .rd_cpl_tag   (rd_cpl_tag),
    .rd_cpl_data  (rd_cpl_data),
    .wr_cpl_valid (wr_cpl_valid),
    .wr_cpl_tag   (wr_cpl_tag),
    .read_done    (read_done),
    .data         (data),
    .rd_ready     (rd_ready),
    .write_done   (write_done),
    .wr_ready     (wr_ready),
    .cpl_err      (cpl_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [TW-1:0] tag;
    bit            cpl;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          rq[$];
  ent_t          wq[$];
  int            rnext, wnext;
  logic          m_rdone, m_wdone;
  logic [DW-1:0] m_data;
  logic [1:0]    m_err;
  logic [DW-1:0] exp_q[$];
  int            cand[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    wq.delete();
    rnext   = 0;
    wnext   = 0;
    m_rdone = 1'b0;
    m_wdone = 1'b0;
    m_data  = '0;
    m_err   = 2'b00;
  endtask

  function automatic int find_tag(input bit is_rd, input logic [TW-1:0] t);
    int idx = -1;
    if (is_rd) begin
      foreach (rq[i]) if (rq[i].tag == t) idx = i;
    end else begin
      foreach (wq[i]) if (wq[i].tag == t) idx = i;
    end
    return idx;
  endfunction

  // Advances the model across one rising edge using the inputs now driven.
  task automatic model_edge();
    bit rret, wret, rok, wok;
    int idx;
    ent_t e;
    if (rst) begin
      model_reset();
      return;
    end
    rok  = (rq.size() < DEPTH);
    wok  = (wq.size() < DEPTH);
    rret = (rq.size() > 0) && rq[0].cpl && (!m_rdone || rd_ready);
    wret = (wq.size() > 0) && wq[0].cpl && (!m_wdone || wr_ready);
    if (rd_cpl_valid) begin
      idx = find_tag(1'b1, rd_cpl_tag);
      if (idx >= 0 && !rq[idx].cpl) begin
        rq[idx].cpl = 1'b1;
        rq[idx].d   = rd_cpl_data;
      end else m_err[0] = 1'b1;
    end
    if (wr_cpl_valid) begin
      idx = find_tag(1'b0, wr_cpl_tag);
      if (idx >= 0 && !wq[idx].cpl) wq[idx].cpl = 1'b1;
      else m_err[1] = 1'b1;
    end
    if (rret) begin
      m_rdone = 1'b1;
      m_data  = rq[0].d;
      void'(rq.pop_front());
    end else if (rd_ready) begin
      m_rdone = 1'b0;
      m_data  = '0;
    end
    if (wret) begin
      m_wdone = 1'b1;
      void'(wq.pop_front());
    end else if (wr_ready) begin
      m_wdone = 1'b0;
    end
    if (rd_alloc && rok) begin
      e.tag = rnext[TW-1:0]; e.cpl = 1'b0; e.d = '0;
      rq.push_back(e);
      rnext = (rnext + 1) % DEPTH;
    end
    if (wr_alloc && wok) begin
      e.tag = wnext[TW-1:0]; e.cpl = 1'b0; e.d = '0;
      wq.push_back(e);
      wnext = (wnext + 1) % DEPTH;
    end
  endtask

  task automatic check_outputs();
    chk("read_done",    read_done,    m_rdone);
    chk("data",         data,         m_data);
    chk("write_done",   write_done,   m_wdone);
    chk("rd_alloc_ok",  rd_alloc_ok,  rq.size() != DEPTH);
    chk("wr_alloc_ok",  wr_alloc_ok,  wq.size() != DEPTH);
    chk("rd_alloc_tag", rd_alloc_tag, rnext);
    chk("wr_alloc_tag", wr_alloc_tag, wnext);
    chk("cpl_err",      cpl_err,      m_err);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_alloc     = 1'b0;
    wr_alloc     = 1'b0;
    rd_cpl_valid = 1'b0;
    wr_cpl_valid = 1'b0;
    rd_cpl_tag   = '0;
    wr_cpl_tag   = '0;
    rd_cpl_data  = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic rd_cpl(input logic [TW-1:0] t, input logic [DW-1:0] d);
    idle();
    rd_cpl_valid = 1'b1;
    rd_cpl_tag   = t;
    rd_cpl_data  = d;
    step();
    idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    rst      = 1'b1;
    rd_ready = 1'b1;
    wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;

    // Reset mid-traffic discards pending returns.
    rd_ready = 1'b0;
    wr_ready = 1'b0;
    rd_alloc = 1'b1; wr_alloc = 1'b1;
    repeat (2) step();
    idle();
    rd_cpl(0, 32'h1111);
    rd_cpl(1, 32'h2222);
    wr_cpl_valid = 1'b1; wr_cpl_tag = 0;
    step();
    do_reset();
    chk("t1_read_done", read_done, 1'b0);
    chk("t1_write_done", write_done, 1'b0);
    chk("t1_data", data, 0);
    chk("t1_err", cpl_err, 2'b00);
    chk("t1_rd_ok", rd_alloc_ok, 1'b1);
    chk("t1_wr_ok", wr_alloc_ok, 1'b1);
    chk("t1_rd_tag", rd_alloc_tag, 0);
    chk("t1_wr_tag", wr_alloc_tag, 0);
    rd_ready = 1'b1; wr_ready = 1'b1;
    repeat (4) step();

    // Out-of-order completion, in-order return.
    do_reset();
    rd_alloc = 1'b1;
    repeat (3) step();
    idle();
    exp_q.push_back(32'hA); exp_q.push_back(32'hB); exp_q.push_back(32'hC);
    rd_cpl(2, 32'hC);
    rd_cpl(1, 32'hB);
    rd_cpl(0, 32'hA);
    chk("t2_no_bypass", read_done, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("t2_done", read_done, 1'b1);
      chk("t2_data", data, exp_q.pop_front());
      step();
    end
    chk("t2_drained", read_done, 1'b0);

    // Full ring and tag wrap.
    do_reset();
    rd_alloc = 1'b1;
    repeat (DEPTH) step();
    chk("t3_full", rd_alloc_ok, 1'b0);
    chk("t3_tail_wrap", rd_alloc_tag, 0);
    step();
    idle();
    rd_cpl(0, 32'h5);
    step();
    chk("t3_ok_after_retire", rd_alloc_ok, 1'b1);
    chk("t3_next_tag", rd_alloc_tag, 0);
    rd_alloc = 1'b1;
    step();
    idle();
    chk("t3_tag_after", rd_alloc_tag, 1);
    chk("t3_full_again", rd_alloc_ok, 1'b0);

    // Backpressure holds the output stage.
    do_reset();
    rd_ready = 1'b0;
    rd_alloc = 1'b1;
    repeat (2) step();
    idle();
    rd_cpl(0, 32'h11);
    rd_cpl(1, 32'h22);
    repeat (2) step();
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_done", read_done, 1'b1);
      chk("t4_hold_data", data, 32'h11);
      step();
    end
    rd_ready = 1'b1;
    step();
    chk("t4_next_data", data, 32'h22);
    step();

    // Concurrent read and write completions with new allocations.
    do_reset();
    rd_alloc = 1'b1; wr_alloc = 1'b1;
    step();
    rd_cpl_valid = 1'b1; rd_cpl_tag = 0; rd_cpl_data = 32'hBEEF;
    wr_cpl_valid = 1'b1; wr_cpl_tag = 0;
    step();
    idle();
    step();
    chk("t5_read_done", read_done, 1'b1);
    chk("t5_write_done", write_done, 1'b1);
    chk("t5_data", data, 32'hBEEF);
    chk("t5_rd_tag", rd_alloc_tag, 2);
    chk("t5_wr_tag", wr_alloc_tag, 2);
    step();

    // Error flags.
    do_reset();
    rd_ready = 1'b0;
    rd_alloc = 1'b1;
    step();
    idle();
    rd_cpl(0, 32'h77);
    wr_cpl_valid = 1'b1; wr_cpl_tag = 5;
    step();
    idle();
    chk("t6_err_wr", cpl_err, 2'b10);
    rd_cpl(0, 32'h99);
    chk("t6_err_both", cpl_err, 2'b11);
    chk("t6_done", read_done, 1'b1);
    chk("t6_data", data, 32'h77);
    rd_ready = 1'b1;
    repeat (2) step();

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      idle();
      rd_alloc = ($urandom_range(0, 3) != 0);
      wr_alloc = ($urandom_range(0, 3) != 0);
      rd_ready = ($urandom_range(0, 3) != 0);
      wr_ready = ($urandom_range(0, 3) != 0);
      cand.delete();
      foreach (rq[i]) if (!rq[i].cpl) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        rd_cpl_valid = 1'b1;
        rd_cpl_tag   = rq[cand[$urandom_range(0, cand.size() - 1)]].tag;
        rd_cpl_data  = $urandom;
      end
      cand.delete();
      foreach (wq[i]) if (!wq[i].cpl) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        wr_cpl_valid = 1'b1;
        wr_cpl_tag   = wq[cand[$urandom_range(0, cand.size() - 1)]].tag;
      end
      step();
    end
    idle();
    step();

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
